riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_pkg.sv | 15 +
 rtl/riscv_arb_grant.sv | 27 ++
 rtl/riscv_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Purpose: shared FSM state encoding and default geometry for the memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package riscv_mem_pkg;

   localparam int ARB_DATA_WIDTH = 128;
   localparam int ARB_S_ADDR     = 23;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/riscv_arb_grant.sv
// Purpose: picks the icache or dcache requester; on a tie the one not granted last wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only acts on the grant while its FSM is idle.
module riscv_arb_grant
   import riscv_mem_pkg::*;
(
   input  logic i_icache_req,
   input  logic i_dcache_req,
   input  logic i_last_d,
   output logic o_grant_i,
   output logic o_grant_d
);

   // Single requester always wins; a tie goes to whoever was not granted last.
   always_comb begin
      o_grant_i = 1'b0;
      o_grant_d = 1'b0;
      if (i_icache_req && i_dcache_req) begin
         o_grant_d = ~i_last_d;
         o_grant_i =  i_last_d;
      end else begin
         o_grant_i = i_icache_req;
         o_grant_d = i_dcache_req;
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Purpose: arbitrates icache reads and dcache reads/writes onto one block memory port.
// Latency: grant at the request edge, strobe next cycle, ready one cycle after mem_ready.
// Backpressure: holds the latched transaction until mem_ready; RISCV_ARB_ROUND_ROBIN_EN enables fair ties.
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int S_ADDR     = ARB_S_ADDR
) (
   input  logic                  i_riscv_arb_clk,
   input  logic                  i_riscv_arb_rst_n,
   input  logic                  i_riscv_arb_icache_rden,
   input  logic [S_ADDR-1:0]     i_riscv_arb_icache_addr,
   output logic                  o_riscv_arb_icache_ready,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_icache_rdata,
   input  logic                  i_riscv_arb_dcache_rden,
   input  logic                  i_riscv_arb_dcache_wren,
   input  logic [S_ADDR-1:0]     i_riscv_arb_dcache_addr,
   input  logic [DATA_WIDTH-1:0] i_riscv_arb_dcache_wdata,
   output logic                  o_riscv_arb_dcache_ready,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_dcache_rdata,
   output logic                  o_riscv_arb_mem_rden,
   output logic                  o_riscv_arb_mem_wren,
   output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
   input  logic                  i_riscv_arb_mem_ready,
   input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata
);

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   logic [S_ADDR-1:0]     r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_op_wr;
   logic                  r_icache_ready;
   logic                  r_dcache_ready;
   logic [DATA_WIDTH-1:0] r_icache_rdata;
   logic [DATA_WIDTH-1:0] r_dcache_rdata;
   logic                  w_icache_req;
   logic                  w_dcache_req;
   logic                  w_grant_i;
   logic                  w_grant_d;
   logic                  w_last_d;

   // A requester whose ready is pulsing this cycle is masked so its held request is seen as new next cycle.
   assign w_icache_req = i_riscv_arb_icache_rden & ~r_icache_ready;
   assign w_dcache_req = (i_riscv_arb_dcache_rden | i_riscv_arb_dcache_wren) & ~r_dcache_ready;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
   logic r_last_d;

   // Remember who won the most recent grant; reset means "icache went last".
   always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst_n) begin
      if (!i_riscv_arb_rst_n) begin
         r_last_d <= 1'b0;
      end else if (r_state == IDLE && (w_grant_i || w_grant_d)) begin
         r_last_d <= w_grant_d;
      end
   end

   assign w_last_d = r_last_d;
`else
   // Pointer pinned to "icache went last" so every tie resolves to dcache.
   assign w_last_d = 1'b0;
`endif

   riscv_arb_grant u_grant (
      .i_icache_req (w_icache_req),
      .i_dcache_req (w_dcache_req),
      .i_last_d     (w_last_d),
      .o_grant_i    (w_grant_i),
      .o_grant_d    (w_grant_d)
   );

   // State register.
   always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst_n) begin
      if (!i_riscv_arb_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and memory strobes; strobes come only from latched op while serving.
   always_comb begin
      w_next_state         = r_state;
      o_riscv_arb_mem_rden = 1'b0;
      o_riscv_arb_mem_wren = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_d)      w_next_state = SERVE_D;
            else if (w_grant_i) w_next_state = SERVE_I;
         end
         SERVE_I, SERVE_D: begin
            o_riscv_arb_mem_rden = ~r_op_wr;
            o_riscv_arb_mem_wren =  r_op_wr;
            if (i_riscv_arb_mem_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Latch the winner at grant, capture read data and pulse ready when memory completes.
   always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst_n) begin
      if (!i_riscv_arb_rst_n) begin
         r_addr         <= '0;
         r_wdata        <= '0;
         r_op_wr        <= 1'b0;
         r_icache_ready <= 1'b0;
         r_dcache_ready <= 1'b0;
         r_icache_rdata <= '0;
         r_dcache_rdata <= '0;
      end else begin
         r_icache_ready <= 1'b0;
         r_dcache_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_addr  <= i_riscv_arb_dcache_addr;
                  r_wdata <= i_riscv_arb_dcache_wdata;
                  r_op_wr <= i_riscv_arb_dcache_wren;
               end else if (w_grant_i) begin
                  r_addr  <= i_riscv_arb_icache_addr;
                  r_wdata <= '0;
                  r_op_wr <= 1'b0;
               end
            end
            SERVE_I: begin
               if (i_riscv_arb_mem_ready) begin
                  r_icache_ready <= 1'b1;
                  r_icache_rdata <= i_riscv_arb_mem_rdata;
               end
            end
            SERVE_D: begin
               if (i_riscv_arb_mem_ready) begin
                  r_dcache_ready <= 1'b1;
                  if (!r_op_wr) r_dcache_rdata <= i_riscv_arb_mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_riscv_arb_mem_addr     = r_addr;
   assign o_riscv_arb_mem_wdata    = r_wdata;
   assign o_riscv_arb_icache_ready = r_icache_ready;
   assign o_riscv_arb_dcache_ready = r_dcache_ready;
   assign o_riscv_arb_icache_rdata = r_icache_rdata;
   assign o_riscv_arb_dcache_rdata = r_dcache_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Purpose: directed self-checking bench for riscv_mem_arbiter (default and RISCV_ARB_ROUND_ROBIN_EN builds).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: memory completion driven by hand at fixed cycles.
module tb_riscv_mem_arbiter;

   localparam int DW = 128;
   localparam int AW = 23;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ic_rden = 1'b0;
   logic [AW-1:0] ic_addr = '0;
   logic          ic_ready;
   logic [DW-1:0] ic_rdata;
   logic          dc_rden = 1'b0;
   logic          dc_wren = 1'b0;
   logic [AW-1:0] dc_addr = '0;
   logic [DW-1:0] dc_wdata = '0;
   logic          dc_ready;
   logic [DW-1:0] dc_rdata;
   logic          mem_rden;
   logic          mem_wren;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
   localparam logic [DW-1:0] PAT_D1 = {4{32'hD1D1_0001}};
   localparam logic [DW-1:0] PAT_I1 = {4{32'h1111_0CE1}};
   localparam logic [DW-1:0] PAT_T2 = {4{32'h7E57_0002}};
   localparam logic [DW-1:0] PAT_I2 = {4{32'h1CAC_4E02}};

   riscv_mem_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
      .i_riscv_arb_clk          (clk),
      .i_riscv_arb_rst_n        (rst_n),
      .i_riscv_arb_icache_rden  (ic_rden),
      .i_riscv_arb_icache_addr  (ic_addr),
      .o_riscv_arb_icache_ready (ic_ready),
      .o_riscv_arb_icache_rdata (ic_rdata),
      .i_riscv_arb_dcache_rden  (dc_rden),
      .i_riscv_arb_dcache_wren  (dc_wren),
      .i_riscv_arb_dcache_addr  (dc_addr),
      .i_riscv_arb_dcache_wdata (dc_wdata),
      .o_riscv_arb_dcache_ready (dc_ready),
      .o_riscv_arb_dcache_rdata (dc_rdata),
      .o_riscv_arb_mem_rden     (mem_rden),
      .o_riscv_arb_mem_wren     (mem_wren),
      .o_riscv_arb_mem_addr     (mem_addr),
      .o_riscv_arb_mem_wdata    (mem_wdata),
      .i_riscv_arb_mem_ready    (mem_ready),
      .i_riscv_arb_mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state.
      step();
      step();
      chk("rst_rden",  DW'(mem_rden),  DW'(1'b0));
      chk("rst_wren",  DW'(mem_wren),  DW'(1'b0));
      chk("rst_addr",  DW'(mem_addr),  '0);
      chk("rst_wdata", mem_wdata,      '0);
      chk("rst_ready", DW'({ic_ready, dc_ready}), '0);
      chk("rst_rdata", ic_rdata | dc_rdata, '0);
      rst_n = 1'b1;
      step();

      // Icache read, mem_ready at cycle 4 -> ready at cycle 5.
      ic_rden = 1'b1; ic_addr = 23'h00010;              // cycle 0
      chk("c0_rden_idle", DW'(mem_rden), DW'(1'b0));
      step();                                            // cycle 1
      chk("c1_rden", DW'({mem_rden, mem_wren}), DW'(2'b10));
      chk("c1_addr", DW'(mem_addr), DW'(23'h00010));
      step(); step(); step();                            // cycle 4
      chk("c4_ready_lo", DW'(ic_ready), DW'(1'b0));
      mem_ready = 1'b1; mem_rdata = PAT_A5;
      step();                                            // cycle 5
      mem_ready = 1'b0; mem_rdata = '0;
      chk("c5_ic_ready", DW'(ic_ready), DW'(1'b1));
      chk("c5_ic_rdata", ic_rdata, PAT_A5);
      chk("c5_rden_lo",  DW'(mem_rden), DW'(1'b0));
      step();                                            // cycle 6: held request not regranted
      ic_rden = 1'b0;
      chk("c6_no_regrant", DW'(mem_rden), DW'(1'b0));
      chk("c6_pulse_once", DW'(ic_ready), DW'(1'b0));
      step();

      // Tie: dcache first, icache strobe two cycles after mem_ready.
      ic_rden = 1'b1; ic_addr = 23'h00111;
      dc_rden = 1'b1; dc_addr = 23'h00222;
      step();
      chk("tie1_d_addr", DW'(mem_addr), DW'(23'h00222));
      chk("tie1_d_rden", DW'(mem_rden), DW'(1'b1));
      mem_ready = 1'b1; mem_rdata = PAT_D1;
      step();
      mem_ready = 1'b0;
      chk("tie1_dc_ready", DW'({dc_ready, ic_ready}), DW'(2'b10));
      chk("tie1_dc_rdata", dc_rdata, PAT_D1);
      dc_rden = 1'b0;
      step();
      chk("tie1_i_addr", DW'(mem_addr), DW'(23'h00111));
      chk("tie1_i_rden", DW'(mem_rden), DW'(1'b1));
      mem_ready = 1'b1; mem_rdata = PAT_I1;
      step();
      mem_ready = 1'b0;
      ic_rden = 1'b0;
      chk("tie1_ic_ready", DW'(ic_ready), DW'(1'b1));
      chk("tie1_ic_rdata", ic_rdata, PAT_I1);
      chk("tie1_dc_hold",  dc_rdata, PAT_D1);
      step();

      // Dcache write with rden=wren=1, address/data held from latch.
      dc_rden = 1'b1; dc_wren = 1'b1; dc_addr = 23'h7FFFFF; dc_wdata = DW'(16'h1234);
      step();
      chk("wr_strobes", DW'({mem_rden, mem_wren}), DW'(2'b01));
      chk("wr_addr",    DW'(mem_addr), DW'(23'h7FFFFF));
      chk("wr_wdata",   mem_wdata, DW'(16'h1234));
      dc_addr = 23'h000055; dc_wdata = DW'(16'hBEEF);
      step();
      chk("wr_addr_hold",  DW'(mem_addr), DW'(23'h7FFFFF));
      chk("wr_wdata_hold", mem_wdata, DW'(16'h1234));
      chk("wr_wren_hold",  DW'(mem_wren), DW'(1'b1));
      mem_ready = 1'b1; mem_rdata = PAT_T2;
      step();
      mem_ready = 1'b0;
      dc_rden = 1'b0; dc_wren = 1'b0;
      chk("wr_dc_ready", DW'(dc_ready), DW'(1'b1));
      chk("wr_rdata_kept", dc_rdata, PAT_D1);
      step();

      // Second tie after a dcache grant.
      ic_rden = 1'b1; ic_addr = 23'h00333;
      dc_rden = 1'b1; dc_addr = 23'h00444;
      step();
`ifdef RISCV_ARB_ROUND_ROBIN_EN
      chk("tie2_addr", DW'(mem_addr), DW'(23'h00333));
`else
      chk("tie2_addr", DW'(mem_addr), DW'(23'h00444));
`endif
      chk("tie2_rden", DW'(mem_rden), DW'(1'b1));
      mem_ready = 1'b1; mem_rdata = PAT_T2;
      step();
      mem_ready = 1'b0;
      ic_rden = 1'b0; dc_rden = 1'b0;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
      chk("tie2_ready", DW'({ic_ready, dc_ready}), DW'(2'b10));
`else
      chk("tie2_ready", DW'({ic_ready, dc_ready}), DW'(2'b01));
`endif
      step();

      // Reset during SERVE_D wait cycle 2.
      dc_rden = 1'b1; dc_addr = 23'h00055;
      step();                                            // wait cycle 1
      chk("rst_pre_rden", DW'(mem_rden), DW'(1'b1));
      step();                                            // wait cycle 2
      rst_n = 1'b0;
      dc_rden = 1'b0;
      #1;
      chk("rst_mid_strobes", DW'({mem_rden, mem_wren}), '0);
      chk("rst_mid_addr",    DW'(mem_addr), '0);
      chk("rst_mid_rdata",   dc_rdata | ic_rdata, '0);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("rst_no_ready", DW'({ic_ready, dc_ready}), '0);
      rst_n = 1'b1;
      step();
      chk("rst_rel_idle", DW'({mem_rden, mem_wren, dc_ready}), '0);

      // Stray mem_ready in IDLE, then icache request dropped after grant.
      mem_ready = 1'b1; mem_rdata = {4{32'hBAD0_BAD0}};
      step();
      mem_ready = 1'b0;
      chk("stray_ready", DW'({ic_ready, dc_ready, mem_rden}), '0);
      chk("stray_rdata", ic_rdata | dc_rdata, '0);
      ic_rden = 1'b1; ic_addr = 23'h000AB;
      step();
      chk("drop_grant", DW'(mem_rden), DW'(1'b1));
      ic_rden = 1'b0;
      step();
      chk("drop_hold_rden", DW'(mem_rden), DW'(1'b1));
      chk("drop_hold_addr", DW'(mem_addr), DW'(23'h000AB));
      mem_ready = 1'b1; mem_rdata = PAT_I2;
      step();
      mem_ready = 1'b0;
      chk("drop_ic_ready", DW'(ic_ready), DW'(1'b1));
      chk("drop_ic_rdata", ic_rdata, PAT_I2);
      step();
      chk("drop_end_idle", DW'({ic_ready, mem_rden}), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
